// File: rtl/alu_result_queue.sv
// alu_result_queue
//   Buffers ALU compare/set results in a small circular FIFO so a stalled
//   consumer never forces the ALU to drop a result. It also keeps status on
//   accepted entries: a saturating zero count, a sticky zero indicator and a
//   sticky flag/result disagreement bit.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready = !full)
//   in_result, in_flag  ALU result and its zero flag
//   out_valid/out_ready downstream handshake (out_valid = !empty)
//   out_result,out_flag head entry, read combinationally from storage
//   count               current occupancy
//   zero_cnt            saturating count of accepted entries with in_flag=1
//   zero_seen           sticky: some accepted entry had in_flag=1
//   flag_err            sticky: some accepted entry had in_flag != (in_result==0)
//   clr                 clears zero_cnt/zero_seen/flag_err only
module alu_result_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  logic                     in_flag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic                     out_flag,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         zero_cnt,
  output logic                     zero_seen,
  output logic                     flag_err,
  input  logic                     clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Ready depends only on registered occupancy, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_result = mem[rd_ptr][32:1];
  assign out_flag   = mem[rd_ptr][0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_result, in_flag};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // clr takes priority over the status contribution of a same-cycle push;
  // the entry itself is still enqueued above.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      zero_cnt  <= '0;
      zero_seen <= 1'b0;
      flag_err  <= 1'b0;
    end else if (push) begin
      if (in_flag && (zero_cnt != '1)) zero_cnt <= zero_cnt + CNT_W'(1);
      if (in_flag) zero_seen <= 1'b1;
      if (in_flag != (in_result == 32'h0)) flag_err <= 1'b1;
    end
  end

endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Downstream buffering stage for the ALU compare/set units (SGE and its siblings). It accepts each 32-bit result and its zero flag over a valid/ready handshake and holds them in a small FIFO, so a stalled consumer (writeback or branch unit) never forces the ALU to drop a result. Alongside the FIFO it keeps a small set of status registers:
- a saturating count of zero-flagged results;
- a sticky zero indicator;
- a sticky error bit that fires when the flag disagrees with the result.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- CNT_W, 16: width of zero_cnt.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has a result this cycle.
- in_ready  output  1  queue can accept; equals !full, driven from registered state only.
- in_result  input  32  ALU result (all-ones or zero for compare ops; any value accepted).
- in_flag  input  1  ALU zero flag (1 = result is zero).
- out_valid  output  1  head entry present; equals !empty.
- out_ready  input  1  downstream consumes head this cycle.
- out_result  output  32  head entry result.
- out_flag  output  1  head entry flag.
- count  output  $clog2(DEPTH)+1  current occupancy.
- zero_cnt  output  CNT_W  accepted entries with in_flag=1; saturating.
- zero_seen  output  1  sticky: at least one accepted entry had in_flag=1.
- flag_err  output  1  sticky: an accepted entry had in_flag != (in_result==0).
- clr  input  1  synchronous clear of zero_cnt, zero_seen and flag_err only; FIFO contents are unaffected.

## Operation
- push = in_valid && in_ready.
- pop = out_valid && out_ready.
- Storage is a circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits and wrapping modulo DEPTH.
- Occupancy is tracked in count; full = (count==DEPTH), empty = (count==0).
- Push writes {in_result, in_flag} at wr_ptr and advances wr_ptr.
- Pop advances rd_ptr.
- out_result/out_flag show the entry at rd_ptr, read combinationally from storage. Their value while out_valid=0 is don't-care but must not be X after reset; storage is reset to 0.
- Push and pop in the same cycle: both pointers advance and count is unchanged.
  - Allowed at any occupancy where in_ready=1.
  - When full, in_ready=0, so no push occurs; this is intentional, to avoid a combinational ready path.
- in_valid while full: ignored; no state change, no error.
- out_ready while empty: ignored.
- Status updates apply only on push:
  - zero_cnt increments if in_flag=1 and holds at 2^CNT_W-1.
  - zero_seen sets if in_flag=1.
  - flag_err sets if in_flag != (in_result==32'h0).
- clr and push in the same cycle: clr wins. Counters and sticky bits go to 0 and that push's status contribution is discarded. The entry is still enqueued.

## Timing
- Reset (rst=1 at a rising edge) drives the following values. rst overrides clr, push and pop.
  - in_ready=1, out_valid=0, out_result=0, out_flag=0, count=0.
  - zero_cnt=0, zero_seen=0, flag_err=0.
  - Pointers=0, storage=0.
- Latency from push to availability is 1 cycle: an entry pushed at edge N is visible on out_* with out_valid=1 after edge N. There is no same-cycle bypass.
- Throughput: 1 entry/cycle sustained with out_ready held high.
- in_ready falls in the cycle after the push that fills the queue. It rises in the cycle after the first pop from full.
- Status outputs reflect a push in the cycle after the push edge.
- Reset mid-operation discards all queued entries. The first edge with rst=0 already accepts a push.

## Test plan
- Reset then single push: rst for 2 cycles, then push {32'hFFFFFFFF, 0} -> after 1 edge out_valid=1, out_result=32'hFFFFFFFF, out_flag=0, count=1, zero_cnt=0, flag_err=0. Pop -> count=0, out_valid=0.
- Fill and overflow (DEPTH=4): push 0x1..0x4 with out_ready=0 -> count=4, in_ready=0.
  - A fifth in_valid with 0x5 is ignored.
  - Then out_ready=1 for 4 cycles -> pops 0x1, 0x2, 0x3, 0x4 in order, with 0x5 never appearing.
- Wrap and simultaneous push/pop: 10 consecutive pushes of values 0..9 with out_ready=1 throughout -> count stays at most 1 and output order is 0..9 across the pointer wrap.
  - From count=2, a push+pop cycle -> count remains 2.
- Status counting: push 3 entries {0,1} and 2 entries {FFFFFFFF,0} -> zero_cnt=3, zero_seen=1, flag_err=0.
  - Then push {0,0} -> flag_err=1.
  - Then clr together with a push of {0,1} -> zero_cnt=0, zero_seen=0, flag_err=0, and the entry is enqueued (count incremented).
- Saturation (CNT_W=4): 20 pushes of {0,1} while draining -> zero_cnt holds at 15.
- Reset mid-stream: with count=3 and zero_cnt=5, assert rst with in_valid=1 -> next cycle count=0, out_valid=0, zero_cnt=0, and nothing is enqueued.
